irq_arbiter: RTL and testbench

Programmable interrupt arbiter between the peripheral interrupt sources and the CP0 `IP[7:2]` inputs. It latches edge or level requests, applies a per-source mask, and tracks in-service sources so that only strictly higher-priority requests reach CP0 while a handler runs. It also exposes a register file on the system bridge for the handler to read the winning vector and signal end-of-interrupt.

---
 rtl/irq_arbiter_pkg.sv | 22 ++
 rtl/irq_arbiter_prio_enc.sv | 32 +++
 rtl/irq_arbiter.sv | 115 +++++++++++
 tb/tb_irq_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/irq_arbiter_pkg.sv
//==============================================================================
// Module      : irq_arbiter_pkg
// Description : Shared register offsets and field positions for irq_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package irq_arbiter_pkg;

   localparam logic [1:0] A_PEND = 2'd0;
   localparam logic [1:0] A_MASK = 2'd1;
   localparam logic [1:0] A_MODE = 2'd2;
   localparam logic [1:0] A_ISR  = 2'd3;

   localparam int              VEC_W    = 3;
   localparam logic [VEC_W-1:0] VEC_NONE = 3'd7;
   localparam int              ISR_LSB  = 8;

endpackage

`default_nettype wire

// File: rtl/irq_arbiter_prio_enc.sv
//==============================================================================
// Module      : prio_enc
// Description : Highest-set-bit encoder with valid flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module prio_enc #(
   parameter int N     = 6,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Ascending scan: the last hit is the highest set bit.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/irq_arbiter.sv
//==============================================================================
// Module      : irq_arbiter
// Description : Edge/level interrupt latch, mask and nesting arbiter for CP0 IP.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module irq_arbiter
   import irq_arbiter_pkg::*;
#(
   parameter int N_SRC = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src,
   input  logic             int_taken,
   input  logic [1:0]       addr,
   input  logic             we,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic [N_SRC-1:0] ip
);

   logic [N_SRC-1:0] r_pend;
   logic [N_SRC-1:0] r_mask;
   logic [N_SRC-1:0] r_mode;
   logic [N_SRC-1:0] r_isr;
   logic [N_SRC-1:0] r_src_prev;

   logic [VEC_W-1:0] w_isr_idx;
   logic             w_isr_valid;
   logic [VEC_W-1:0] w_win_idx;
   logic             w_win_valid;
   logic [VEC_W-1:0] w_vec;
   logic [N_SRC-1:0] w_eligible;
   logic [N_SRC-1:0] w_above;
   logic [N_SRC-1:0] w_ip;
   logic [N_SRC-1:0] w_take_oh;
   logic [N_SRC-1:0] w_eoi_oh;
   logic [N_SRC-1:0] w_w1c;
   logic [N_SRC-1:0] w_rise;
   logic [N_SRC-1:0] w_pend_next;
   logic             w_eoi;
   logic             w_unused_wdata;

   assign w_eligible = r_pend & r_mask;

   prio_enc #(.N(N_SRC), .IDX_W(VEC_W)) u_isr_enc (
      .req   (r_isr),
      .idx   (w_isr_idx),
      .valid (w_isr_valid)
   );

   // Only sources strictly above the highest in-service bit may interrupt.
   for (genvar i = 0; i < N_SRC; i++) begin : g_above
      localparam logic [VEC_W-1:0] c_idx = VEC_W'(i);
      assign w_above[i] = !w_isr_valid || (c_idx > w_isr_idx);
   end

   assign w_ip = w_eligible & w_above;
   assign ip   = w_ip;

   prio_enc #(.N(N_SRC), .IDX_W(VEC_W)) u_vec_enc (
      .req   (w_ip),
      .idx   (w_win_idx),
      .valid (w_win_valid)
   );

   assign w_vec = w_win_valid ? w_win_idx : VEC_NONE;

   assign w_eoi     = we && (addr == A_ISR);
   assign w_w1c     = (we && (addr == A_PEND)) ? wdata[N_SRC-1:0] : '0;
   assign w_take_oh = (int_taken && w_win_valid) ? (N_SRC'(1) << w_win_idx) : '0;
   assign w_eoi_oh  = (w_eoi && w_isr_valid) ? (N_SRC'(1) << w_isr_idx) : '0;
   assign w_rise    = src & ~r_src_prev;

   // Edge bits: new edge beats both W1C and auto-ack. Level bits track src.
   assign w_pend_next = (r_mode & (w_rise | (r_pend & ~w_w1c & ~w_take_oh)))
                      | (~r_mode & src);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend     <= '0;
         r_mask     <= '0;
         r_mode     <= '0;
         r_isr      <= '0;
         r_src_prev <= '0;
      end else begin
         r_src_prev <= src;
         r_pend     <= w_pend_next;
         r_isr      <= (r_isr & ~w_eoi_oh) | w_take_oh;
         if (we && (addr == A_MASK)) r_mask <= wdata[N_SRC-1:0];
         if (we && (addr == A_MODE)) r_mode <= wdata[N_SRC-1:0];
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         A_PEND: rdata[N_SRC-1:0] = r_pend;
         A_MASK: rdata[N_SRC-1:0] = r_mask;
         A_MODE: rdata[N_SRC-1:0] = r_mode;
         default: begin
            rdata[ISR_LSB +: N_SRC] = r_isr;
            rdata[VEC_W-1:0]        = w_vec;
         end
      endcase
   end

   assign w_unused_wdata = ^wdata[31:N_SRC];

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
//==============================================================================
// Module      : tb_irq_arbiter
// Description : Directed self-checking bench for irq_arbiter (N_SRC = 6).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_irq_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  src;
   logic        int_taken;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [5:0]  ip;

   int n_total  = 0;
   int n_passed = 0;

   irq_arbiter #(.N_SRC(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .src       (src),
      .int_taken (int_taken),
      .addr      (addr),
      .we        (we),
      .wdata     (wdata),
      .rdata     (rdata),
      .ip        (ip)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   task automatic chk_ip(input string tag, input logic [5:0] exp);
      check(tag, {26'd0, ip}, {26'd0, exp});
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic pulse(input logic [5:0] v);
      src = v;
      tick();
      src = '0;
   endtask

   task automatic take();
      int_taken = 1'b1;
      tick();
      int_taken = 1'b0;
   endtask

   initial begin
      reset = 1'b1; src = '0; int_taken = 1'b0; addr = '0; we = 1'b0; wdata = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk_ip ("rst_ip", 6'h00);
      chk_reg("rst_pend", 2'd0, 32'h0);
      chk_reg("rst_isr", 2'd3, 32'h0000_0007);

      // Edge set and mask
      wr(2'd2, 32'h3F);
      wr(2'd1, 32'h01);
      pulse(6'h01);
      chk_ip ("edge_ip", 6'h01);
      chk_reg("edge_pend", 2'd0, 32'h1);
      chk_reg("edge_vec", 2'd3, 32'h0000_0000);
      wr(2'd1, 32'h00);
      chk_ip ("masked_ip", 6'h00);
      chk_reg("masked_pend", 2'd0, 32'h1);
      wr(2'd0, 32'h01);
      chk_reg("w1c_pend", 2'd0, 32'h0);

      // Level mode
      wr(2'd2, 32'h00);
      wr(2'd1, 32'h3F);
      src = 6'h08;
      tick();
      chk_ip("level_ip", 6'h08);
      wr(2'd0, 32'h08);
      chk_ip("level_w1c_ip", 6'h08);
      src = 6'h00;
      tick();
      chk_ip("level_drop_ip", 6'h00);

      // Nesting
      wr(2'd2, 32'h3F);
      pulse(6'h12);
      chk_ip("nest_pend_ip", 6'h12);
      take();
      chk_reg("nest_isr1", 2'd3, 32'h0000_1007);
      chk_ip ("nest_ip1", 6'h00);
      pulse(6'h20);
      chk_ip ("nest_ip5", 6'h20);
      chk_reg("nest_vec5", 2'd3, 32'h0000_1005);
      take();
      chk_reg("nest_isr2", 2'd3, 32'h0000_3007);
      chk_reg("nest_pend", 2'd0, 32'h02);

      // EOI ordering
      wr(2'd3, 32'h0);
      chk_reg("eoi1_isr", 2'd3, 32'h0000_1007);
      chk_ip ("eoi1_ip", 6'h00);
      wr(2'd3, 32'h0);
      chk_reg("eoi2_isr", 2'd3, 32'h0000_0001);
      chk_ip ("eoi2_ip", 6'h02);

      // W1C and new edge on the same bit
      src = 6'h04;
      wr(2'd0, 32'h04);
      src = 6'h00;
      chk_reg("w1c_edge_pend", 2'd0, 32'h06);

      // int_taken together with EOI
      take();
      chk_reg("isr04", 2'd3, 32'h0000_0407);
      pulse(6'h20);
      chk_reg("isr04_vec5", 2'd3, 32'h0000_0405);
      int_taken = 1'b1;
      wr(2'd3, 32'h0);
      int_taken = 1'b0;
      chk_reg("take_eoi_isr", 2'd3, 32'h0000_2007);
      chk_ip ("take_eoi_ip", 6'h00);

      // Auto-ack and new edge on the same source
      wr(2'd3, 32'h0);
      chk_ip("pre_ack_ip", 6'h02);
      src = 6'h02;
      take();
      src = 6'h00;
      chk_reg("ack_edge_pend", 2'd0, 32'h02);
      chk_reg("ack_edge_isr", 2'd3, 32'h0000_0207);
      wr(2'd3, 32'h0);

      // Reset mid-handler
      pulse(6'h0F);
      pulse(6'h10);
      take();
      pulse(6'h20);
      take();
      chk_reg("pre_rst_isr", 2'd3, 32'h0000_3007);
      chk_reg("pre_rst_pend", 2'd0, 32'h0F);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_ip ("mid_rst_ip", 6'h00);
      chk_reg("mid_rst_pend", 2'd0, 32'h0);
      chk_reg("mid_rst_mask", 2'd1, 32'h0);
      tick();
      chk_reg("mid_rst_mode", 2'd2, 32'h0);
      chk_reg("mid_rst_isr", 2'd3, 32'h0000_0007);
      pulse(6'h01);
      chk_ip("post_rst_ignored", 6'h00);
      wr(2'd1, 32'h01);
      wr(2'd2, 32'h01);
      pulse(6'h01);
      chk_ip("post_rst_edge", 6'h01);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule

`default_nettype wire
